muon_decay_sequencer: RTL and testbench

//  Sequences the single-pulse threshold trigger into muon-decay events: the first

---
 rtl/muon_daq_pkg.sv | 18 +
 rtl/muon_decay_sequencer_sat_counter.sv | 32 +++
 rtl/muon_decay_sequencer.sv | 155 +++++++++++++++
 tb/tb_muon_decay_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muon_daq_pkg.sv
// Shared definitions for the muon DAQ chain.
// State encoding, default widths and saturation limit.
package muon_daq_pkg;

   localparam int CNT_W  = 16;
   localparam int HOLD_W = 12;
   localparam int STAT_W = 32;

   localparam logic [STAT_W-1:0] SAT_MAX = '1;

   typedef logic [1:0] state_t;

   localparam state_t IDLE    = 2'd0;
   localparam state_t WINDOW  = 2'd1;
   localparam state_t REPORT  = 2'd2;
   localparam state_t HOLDOFF = 2'd3;

endpackage

// File: rtl/muon_decay_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   // next count: clear wins, then increment unless already full
   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc && (q_q != {W{1'b1}})) begin
         q_d = q_q + W'(1);
      end
   end

   // count register
   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/muon_decay_sequencer.sv
// Turns threshold-trigger pulses into muon decay intervals.
// Start edge opens a window; a second edge reports the interval.
module muon_decay_sequencer #(
   parameter int CNT_W  = muon_daq_pkg::CNT_W,
   parameter int HOLD_W = muon_daq_pkg::HOLD_W,
   parameter int STAT_W = muon_daq_pkg::STAT_W
) (
   input  logic              adc_clk,
   input  logic              adc_rst,
   input  logic              enable,
   input  logic              trig_in,
   input  logic [CNT_W-1:0]  veto_len,
   input  logic [CNT_W-1:0]  window_len,
   input  logic [HOLD_W-1:0] holdoff_len,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [CNT_W-1:0]  evt_dt,
   output logic              busy,
   output logic [STAT_W-1:0] n_events,
   output logic [STAT_W-1:0] n_timeouts,
   output logic [STAT_W-1:0] n_lost
);

   import muon_daq_pkg::*;

   state_t            state_q, state_d;
   logic              trig_d_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  veto_q, veto_d;
   logic [CNT_W-1:0]  win_q, win_d;
   logic [CNT_W-1:0]  dt_q, dt_d;
   logic [HOLD_W-1:0] hcnt_q, hcnt_d;
   logic              valid_q, valid_d;

   logic edge_s;
   logic hit;
   logic tmo;
   logic inc_evt;
   logic inc_tmo;
   logic inc_lost;

   assign edge_s = trig_in & ~trig_d_q;
   assign hit    = edge_s && (cnt_q >= veto_q) && (cnt_q <= win_q);
   assign tmo    = !hit && (cnt_q >= win_q);

   // sequencer next-state, interval and holdoff counting
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      veto_d   = veto_q;
      win_d    = win_q;
      dt_d     = dt_q;
      hcnt_d   = hcnt_q;
      valid_d  = valid_q;
      inc_evt  = 1'b0;
      inc_tmo  = 1'b0;
      inc_lost = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (edge_s) begin
                  state_d = WINDOW;
                  cnt_d   = CNT_W'(1);
                  veto_d  = veto_len;
                  win_d   = window_len;
               end
            end
            WINDOW: begin
               if (cnt_q <= win_q) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (hit) begin
                  state_d = REPORT;
                  dt_d    = cnt_q;
                  valid_d = 1'b1;
                  inc_evt = 1'b1;
               end else if (tmo) begin
                  state_d = HOLDOFF;
                  hcnt_d  = holdoff_len;
                  inc_tmo = 1'b1;
               end
            end
            REPORT: begin
               inc_lost = edge_s;
               if (evt_ready) begin
                  state_d = HOLDOFF;
                  hcnt_d  = holdoff_len;
                  valid_d = 1'b0;
               end
            end
            HOLDOFF: begin
               inc_lost = edge_s;
               if (hcnt_q <= HOLD_W'(1)) begin
                  state_d = IDLE;
               end else begin
                  hcnt_d = hcnt_q - HOLD_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // state and datapath registers
   always_ff @(posedge adc_clk) begin
      if (adc_rst) begin
         state_q  <= IDLE;
         trig_d_q <= 1'b0;
         cnt_q    <= '0;
         veto_q   <= '0;
         win_q    <= '0;
         dt_q     <= '0;
         hcnt_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         trig_d_q <= trig_in;
         cnt_q    <= cnt_d;
         veto_q   <= veto_d;
         win_q    <= win_d;
         dt_q     <= dt_d;
         hcnt_q   <= hcnt_d;
         valid_q  <= valid_d;
      end
   end

   sat_counter #(.W(STAT_W)) u_events (
      .clk (adc_clk),
      .clr (adc_rst),
      .inc (inc_evt),
      .q   (n_events)
   );

   sat_counter #(.W(STAT_W)) u_timeouts (
      .clk (adc_clk),
      .clr (adc_rst),
      .inc (inc_tmo),
      .q   (n_timeouts)
   );

   sat_counter #(.W(STAT_W)) u_lost (
      .clk (adc_clk),
      .clr (adc_rst),
      .inc (inc_lost),
      .q   (n_lost)
   );

   assign evt_valid = valid_q;
   assign evt_dt    = dt_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_muon_decay_sequencer.sv
// Bench for muon_decay_sequencer.
// Timestamp-based reference model checked every cycle.
module tb_muon_decay_sequencer;

   logic        adc_clk = 1'b0;
   logic        adc_rst;
   logic        enable;
   logic        trig_in;
   logic [15:0] veto_len;
   logic [15:0] window_len;
   logic [11:0] holdoff_len;
   logic        evt_valid;
   logic        evt_ready;
   logic [15:0] evt_dt;
   logic        busy;
   logic [31:0] n_events;
   logic [31:0] n_timeouts;
   logic [31:0] n_lost;

   int checks = 0;
   int errors = 0;

   always #5 adc_clk = ~adc_clk;

   muon_decay_sequencer dut (
      .adc_clk     (adc_clk),
      .adc_rst     (adc_rst),
      .enable      (enable),
      .trig_in     (trig_in),
      .veto_len    (veto_len),
      .window_len  (window_len),
      .holdoff_len (holdoff_len),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_dt      (evt_dt),
      .busy        (busy),
      .n_events    (n_events),
      .n_timeouts  (n_timeouts),
      .n_lost      (n_lost)
   );

   localparam int M_IDLE = 0;
   localparam int M_WIN  = 1;
   localparam int M_REP  = 2;
   localparam int M_HOLD = 3;

   int     now = 0;
   int     m_mode = M_IDLE;
   int     m_start = 0;
   int     m_hold_end = 0;
   int     m_veto = 0;
   int     m_win = 0;
   bit     m_prev = 0;
   bit     m_valid = 0;
   int     m_dt = 0;
   longint m_ev = 0;
   longint m_to = 0;
   longint m_lost = 0;

   bit seen_valid;
   int seen_dt;

   function automatic longint sat_inc(longint x);
      return (x >= 64'hFFFF_FFFF) ? x : x + 1;
   endfunction

   task automatic check(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d",
                  name, now, act, exp);
      end
   endtask

   // one cycle of the reference behaviour, using elapsed time stamps
   task automatic model_step();
      bit e;
      int el;
      int h;
      e = trig_in && !m_prev;
      m_prev = trig_in;
      h = (holdoff_len == 0) ? 1 : int'(holdoff_len);
      if (adc_rst) begin
         m_mode = M_IDLE;
         m_valid = 0;
         m_dt = 0;
         m_ev = 0;
         m_to = 0;
         m_lost = 0;
         m_prev = 0;
      end else if (!enable) begin
         m_mode = M_IDLE;
         m_valid = 0;
      end else begin
         case (m_mode)
            M_IDLE: if (e) begin
               m_mode = M_WIN;
               m_start = now;
               m_veto = int'(veto_len);
               m_win = int'(window_len);
            end
            M_WIN: begin
               el = now - m_start;
               if (e && el >= m_veto && el <= m_win) begin
                  m_dt = el;
                  m_valid = 1;
                  m_ev = sat_inc(m_ev);
                  m_mode = M_REP;
               end else if (el >= m_win) begin
                  m_to = sat_inc(m_to);
                  m_mode = M_HOLD;
                  m_hold_end = now + h;
               end
            end
            M_REP: begin
               if (e) m_lost = sat_inc(m_lost);
               if (evt_ready) begin
                  m_valid = 0;
                  m_mode = M_HOLD;
                  m_hold_end = now + h;
               end
            end
            default: begin
               if (e) m_lost = sat_inc(m_lost);
               if (now + 1 > m_hold_end) m_mode = M_IDLE;
            end
         endcase
      end
      now++;
   endtask

   task automatic tick();
      model_step();
      @(posedge adc_clk);
      #1;
      if (evt_valid) begin
         seen_valid = 1;
         seen_dt = int'(evt_dt);
      end
      check("evt_valid", evt_valid, m_valid);
      check("evt_dt", evt_dt, m_dt);
      check("busy", busy, (m_mode != M_IDLE));
      check("n_events", n_events, m_ev);
      check("n_timeouts", n_timeouts, m_to);
      check("n_lost", n_lost, m_lost);
   endtask

   task automatic zeros(int n);
      trig_in = 0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse();
      trig_in = 1;
      tick();
      trig_in = 0;
   endtask

   task automatic wait_idle();
      trig_in = 0;
      for (int i = 0; i < 2000 && busy; i++) tick();
      check("reach_idle", busy, 0);
   endtask

   typedef struct {
      int veto;
      int win;
      int hold;
      int gap;
      bit exp_hit;
      int exp_dt;
   } vec_t;

   vec_t vecs[8];

   initial begin
      longint ev0, to0, lost0;
      vecs[0] = '{4, 100, 10, 37, 1, 37};
      vecs[1] = '{4, 100, 10, 2, 0, 0};
      vecs[2] = '{4, 100, 10, 100, 1, 100};
      vecs[3] = '{4, 100, 10, 101, 0, 0};
      vecs[4] = '{0, 0, 0, 2, 0, 0};
      vecs[5] = '{10, 5, 3, 7, 0, 0};
      vecs[6] = '{4, 100, 0, 4, 1, 4};
      vecs[7] = '{4, 100, 0, 3, 0, 0};

      adc_rst = 1;
      enable = 0;
      trig_in = 0;
      evt_ready = 0;
      veto_len = 4;
      window_len = 100;
      holdoff_len = 10;
      tick();
      tick();
      check("rst_valid", evt_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_dt", evt_dt, 0);
      check("rst_events", n_events, 0);
      adc_rst = 0;
      enable = 1;
      zeros(3);

      for (int v = 0; v < 8; v++) begin
         veto_len = 16'(vecs[v].veto);
         window_len = 16'(vecs[v].win);
         holdoff_len = 12'(vecs[v].hold);
         evt_ready = 1;
         wait_idle();
         ev0 = n_events;
         to0 = n_timeouts;
         seen_valid = 0;
         seen_dt = 0;
         pulse();
         zeros(vecs[v].gap - 1);
         pulse();
         wait_idle();
         check($sformatf("vec%0d_hit", v), seen_valid, vecs[v].exp_hit);
         if (vecs[v].exp_hit)
            check($sformatf("vec%0d_dt", v), seen_dt, vecs[v].exp_dt);
         check($sformatf("vec%0d_ev", v), n_events - ev0, vecs[v].exp_hit);
         check($sformatf("vec%0d_to", v), n_timeouts - to0, !vecs[v].exp_hit);
      end

      // stalled readout with extra edges, then holdoff and restart
      veto_len = 4;
      window_len = 100;
      holdoff_len = 10;
      evt_ready = 0;
      wait_idle();
      lost0 = n_lost;
      pulse();
      zeros(36);
      pulse();
      check("stall_valid", evt_valid, 1);
      zeros(10);
      pulse();
      zeros(10);
      pulse();
      zeros(10);
      pulse();
      zeros(17);
      check("stall_valid_held", evt_valid, 1);
      check("stall_dt_held", evt_dt, 37);
      check("stall_lost", n_lost - lost0, 3);
      check("stall_busy", busy, 1);
      evt_ready = 1;
      zeros(1);
      check("handshake_drop", evt_valid, 0);
      zeros(4);
      pulse();
      check("hold_lost", n_lost - lost0, 4);
      zeros(5);
      check("hold_over", busy, 0);
      pulse();
      check("first_idle_start", busy, 1);

      // abort mid-window via enable
      zeros(5);
      enable = 0;
      zeros(1);
      check("abort_busy", busy, 0);
      enable = 1;
      zeros(2);

      // enable drop while reporting
      evt_ready = 0;
      pulse();
      zeros(9);
      pulse();
      check("rep_valid", evt_valid, 1);
      enable = 0;
      zeros(1);
      check("rep_drop", evt_valid, 0);
      enable = 1;
      zeros(2);

      // reset while reporting
      pulse();
      zeros(9);
      pulse();
      check("rep2_valid", evt_valid, 1);
      adc_rst = 1;
      zeros(1);
      adc_rst = 0;
      check("mid_rst_valid", evt_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ev", n_events, 0);
      check("mid_rst_to", n_timeouts, 0);
      check("mid_rst_lost", n_lost, 0);

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         trig_in = ($urandom_range(0, 3) == 0);
         evt_ready = ($urandom_range(0, 9) < 7);
         enable = ($urandom_range(0, 199) != 0);
         adc_rst = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 49) == 0) begin
            veto_len = 16'($urandom_range(0, 8));
            window_len = 16'($urandom_range(0, 30));
            holdoff_len = 12'($urandom_range(0, 8));
         end
         tick();
      end
      adc_rst = 0;
      enable = 1;
      zeros(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
